// File: rtl/input_debouncer.sv
// Two-process-free debouncer: SYNC_STAGES-flop synchronizer feeding a 4-state debounce FSM.
// Define DEBOUNCE_GLITCH_CNT_EN to add the saturating glitch_count output.
module input_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       raw_in,
    output logic       data_out
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    output logic [7:0] glitch_count
`endif
);

    localparam int                 CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        STABLE_LOW,
        WAIT_HIGH,
        STABLE_HIGH,
        WAIT_LOW
    } state_e;

    logic [SYNC_STAGES-1:0] sync_chain_q;
    logic                   sync_q;
    state_e                 state_q;
    logic [CNT_W-1:0]       count_q;
    logic                   data_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_chain_q <= '0;
        end else begin
            sync_chain_q <= {sync_chain_q[SYNC_STAGES-2:0], raw_in};
        end
    end

    assign sync_q = sync_chain_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= STABLE_LOW;
            count_q <= '0;
            data_q  <= 1'b0;
        end else begin
            case (state_q)
                STABLE_LOW, STABLE_HIGH: begin
                    count_q <= '0;
                    if (sync_q != data_q) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state_q <= data_q ? STABLE_LOW : STABLE_HIGH;
                            data_q  <= ~data_q;
                        end else begin
                            state_q <= data_q ? WAIT_LOW : WAIT_HIGH;
                            count_q <= CNT_W'(1);
                        end
                    end
                end
                default: begin
                    if (sync_q == data_q) begin
                        // Bounce rejected: fall back to where we came from.
                        state_q <= data_q ? STABLE_HIGH : STABLE_LOW;
                        count_q <= '0;
                    end else if (count_q == CNT_LAST) begin
                        state_q <= data_q ? STABLE_LOW : STABLE_HIGH;
                        data_q  <= ~data_q;
                        count_q <= '0;
                    end else begin
                        count_q <= count_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign data_out = data_q;

`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic       abort;
    logic [7:0] glitch_cnt_d;
    logic [7:0] glitch_cnt_q;

    assign abort = ((state_q == WAIT_HIGH) || (state_q == WAIT_LOW)) && (sync_q == data_q);

    // NOTE: default assignment first keeps this block purely combinational (no latch).
    always_comb begin
        glitch_cnt_d = glitch_cnt_q;
        if (abort && (glitch_cnt_q != 8'hFF)) begin
            glitch_cnt_d = glitch_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            glitch_cnt_q <= 8'd0;
        end else begin
            glitch_cnt_q <= glitch_cnt_d;
        end
    end

    assign glitch_count = glitch_cnt_q;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer: default build plus a SYNC_STAGES=3 / DEBOUNCE_CYCLES=1 instance.
module tb_input_debouncer;

    logic clk = 1'b0;
    logic reset;
    logic raw_in;
    logic raw1;
    logic data_out;
    logic dout1;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] glitch_count;
    logic [7:0] glitch1;
`endif

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    input_debouncer dut (
        .clk          (clk),
        .reset        (reset),
        .raw_in       (raw_in),
        .data_out     (data_out)
`ifdef DEBOUNCE_GLITCH_CNT_EN
        ,
        .glitch_count (glitch_count)
`endif
    );

    input_debouncer #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(1)) dut1 (
        .clk          (clk),
        .reset        (reset),
        .raw_in       (raw1),
        .data_out     (dout1)
`ifdef DEBOUNCE_GLITCH_CNT_EN
        ,
        .glitch_count (glitch1)
`endif
    );

    // Model of the downstream edge_detector: one-cycle pulse on each data_out rise.
    logic prev_q;
    logic edge_out;
    int   pulse_cnt = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) prev_q <= 1'b0;
        else       prev_q <= data_out;
    end

    assign edge_out = data_out & ~prev_q;

    always @(negedge clk) begin
        if (edge_out) pulse_cnt <= pulse_cnt + 1;
    end

    task automatic do_reset();
        @(negedge clk);
        reset  = 1'b1;
        raw_in = 1'b0;
        raw1   = 1'b0;
        @(negedge clk);
        reset  = 1'b0;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        raw_in = 1'b0;
        raw1   = 1'b0;
        #12;
        n_cmp++;
        if (data_out !== 1'b0) begin
            n_mis++;
            $display("FAIL reset_data_out: got %b expected 0", data_out);
        end
        n_cmp++;
        if (dout1 !== 1'b0) begin
            n_mis++;
            $display("FAIL reset_dout1: got %b expected 0", dout1);
        end
`ifdef DEBOUNCE_GLITCH_CNT_EN
        n_cmp++;
        if (glitch_count !== 8'd0) begin
            n_mis++;
            $display("FAIL reset_glitch_count: got %0d expected 0", glitch_count);
        end
`endif
    endtask

    // Reset released at 24 ns with raw_in stepping high; first sampling edge is 25 ns.
    task automatic test_clean_step();
        logic exp;
        #12;
        reset  = 1'b0;
        raw_in = 1'b1;
        for (int e = 1; e <= 11; e++) begin
            @(posedge clk);
            #1;
            exp = (e >= 6);
            n_cmp++;
            if (data_out !== exp) begin
                n_mis++;
                $display("FAIL clean_step edge %0d: got %b expected %b", e, data_out, exp);
            end
        end
    endtask

    task automatic test_glitch();
        do_reset();
        raw_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        raw_in = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (data_out !== 1'b0) begin
                n_mis++;
                $display("FAIL glitch_hold edge %0d: got %b expected 0", e, data_out);
            end
        end
`ifdef DEBOUNCE_GLITCH_CNT_EN
        n_cmp++;
        if (glitch_count !== 8'd1) begin
            n_mis++;
            $display("FAIL glitch_count_one: got %0d expected 1", glitch_count);
        end
`endif
    endtask

    task automatic test_bounce();
        int   snap;
        logic exp;
        do_reset();
        snap = pulse_cnt;
        for (int i = 0; i < 8; i++) begin
            raw_in = ((i % 2) == 0);
            @(negedge clk);
            n_cmp++;
            if (data_out !== 1'b0) begin
                n_mis++;
                $display("FAIL bounce_burst step %0d: got %b expected 0", i, data_out);
            end
        end
        raw_in = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            @(posedge clk);
            #1;
            exp = (e == 6);
            n_cmp++;
            if (data_out !== exp) begin
                n_mis++;
                $display("FAIL bounce_rise edge %0d: got %b expected %b", e, data_out, exp);
            end
        end
        repeat (4) @(negedge clk);
        n_cmp++;
        if ((pulse_cnt - snap) !== 1) begin
            n_mis++;
            $display("FAIL bounce_edge_pulses: got %0d expected 1", pulse_cnt - snap);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        raw_in = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        n_cmp++;
        if (data_out !== 1'b1) begin
            n_mis++;
            $display("FAIL async_pre_high: got %b expected 1", data_out);
        end
        #1;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (data_out !== 1'b0) begin
            n_mis++;
            $display("FAIL async_reset_immediate: got %b expected 0", data_out);
        end
        @(negedge clk);
        reset  = 1'b0;
        raw_in = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        logic exp;
        do_reset();
        raw_in = 1'b1;
        // Edge 3 enters WAIT_HIGH with count 1, edge 4 leaves count at 2.
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (data_out !== 1'b0) begin
                n_mis++;
                $display("FAIL midwait_pre edge %0d: got %b expected 0", e, data_out);
            end
        end
        #1;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (data_out !== 1'b0) begin
            n_mis++;
            $display("FAIL midwait_in_reset: got %b expected 0", data_out);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            @(posedge clk);
            #1;
            exp = (e == 6);
            n_cmp++;
            if (data_out !== exp) begin
                n_mis++;
                $display("FAIL midwait_post edge %0d: got %b expected %b", e, data_out, exp);
            end
        end
    endtask

    task automatic test_falling();
        logic exp;
        do_reset();
        raw_in = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        n_cmp++;
        if (data_out !== 1'b1) begin
            n_mis++;
            $display("FAIL fall_pre_high: got %b expected 1", data_out);
        end
        @(negedge clk);
        raw_in = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            @(posedge clk);
            #1;
            exp = (e < 6);
            n_cmp++;
            if (data_out !== exp) begin
                n_mis++;
                $display("FAIL fall edge %0d: got %b expected %b", e, data_out, exp);
            end
        end
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            raw_in = 1'b1;
            @(negedge clk);
            raw_in = 1'b0;
            n_cmp++;
            if (data_out !== 1'b0) begin
                n_mis++;
                $display("FAIL fall_glitch %0d: got %b expected 0", i, data_out);
            end
`ifdef DEBOUNCE_GLITCH_CNT_EN
            if (i == 9) begin
                repeat (4) @(negedge clk);
                n_cmp++;
                if (glitch_count !== 8'd10) begin
                    n_mis++;
                    $display("FAIL glitch_count_ten: got %0d expected 10", glitch_count);
                end
            end
`endif
        end
        repeat (4) @(negedge clk);
        n_cmp++;
        if (data_out !== 1'b0) begin
            n_mis++;
            $display("FAIL fall_after_glitches: got %b expected 0", data_out);
        end
`ifdef DEBOUNCE_GLITCH_CNT_EN
        n_cmp++;
        if (glitch_count !== 8'd255) begin
            n_mis++;
            $display("FAIL glitch_count_saturate: got %0d expected 255", glitch_count);
        end
`endif
    endtask

    task automatic test_fast_config();
        logic exp;
        do_reset();
        raw1 = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            @(posedge clk);
            #1;
            exp = (e >= 4);
            n_cmp++;
            if (dout1 !== exp) begin
                n_mis++;
                $display("FAIL fast_rise edge %0d: got %b expected %b", e, dout1, exp);
            end
        end
        @(negedge clk);
        raw1 = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            @(posedge clk);
            #1;
            exp = (e < 4);
            n_cmp++;
            if (dout1 !== exp) begin
                n_mis++;
                $display("FAIL fast_fall edge %0d: got %b expected %b", e, dout1, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_step();
        test_glitch();
        test_bounce();
        test_async_reset();
        test_reset_mid_wait();
        test_falling();
        test_fast_config();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/input_debouncer.md
INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, meaning the number of synchronizer flops on the raw input (legal range 2..4).
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning the consecutive stable synchronized cycles required before the output changes (legal range 1..65535).
REQ-003 The block SHALL have port clk, input, 1 bit: the single rising-edge clock.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port raw_in, input, 1 bit: asynchronous, bouncy level from a pin or switch.
REQ-006 The block SHALL have port data_out, output, 1 bit: clean registered level that drives the downstream edge_detector data_in.
REQ-007 The block SHALL have port glitch_count, output, 8 bits: count of rejected bounces, present only when the macro in REQ-023 is defined.

Function
REQ-008 The block SHALL pass raw_in through a chain of SYNC_STAGES flops; sync_q SHALL be the last flop output, and no other logic SHALL sample raw_in.
REQ-009 The block SHALL implement FSM states STABLE_LOW, WAIT_HIGH, STABLE_HIGH and WAIT_LOW, with data_out = 0 in STABLE_LOW/WAIT_HIGH and 1 in STABLE_HIGH/WAIT_LOW.
REQ-010 The counter SHALL be $clog2(DEBOUNCE_CYCLES+1) bits wide, unsigned, and SHALL never wrap.
REQ-011 In a STABLE state with sync_q == data_out, the block SHALL hold the state and counter = 0.
REQ-012 In a STABLE state with sync_q != data_out, the block SHALL go to the matching WAIT state with counter = 1; if DEBOUNCE_CYCLES == 1 it SHALL instead go directly to the opposite STABLE state and toggle data_out on that edge.
REQ-013 In a WAIT state with sync_q != data_out and counter == DEBOUNCE_CYCLES-1, the block SHALL enter the opposite STABLE state, toggle data_out and clear the counter on that edge.
REQ-014 In a WAIT state with sync_q != data_out and counter < DEBOUNCE_CYCLES-1, the block SHALL increment the counter.
REQ-015 In a WAIT state with sync_q == data_out, the block SHALL abort to the originating STABLE state, clear the counter and leave data_out unchanged (bounce rejected).
REQ-016 For a clean raw_in step, data_out SHALL change on exactly rising edge number SYNC_STAGES+DEBOUNCE_CYCLES counted from the first edge that samples the new level (edge 6 with defaults).
REQ-017 Any raw_in pulse shorter than DEBOUNCE_CYCLES synchronized cycles SHALL never reach data_out.
REQ-018 data_out SHALL be driven directly from a flop, with no combinational path from raw_in, and SHALL change at most once per DEBOUNCE_CYCLES cycles.

Reset
REQ-019 While reset is high, all synchronizer flops SHALL be 0, the state SHALL be STABLE_LOW, the counter 0, data_out 0, and glitch_count (if present) 0.
REQ-020 Reset SHALL act immediately and asynchronously, and an assertion mid-WAIT SHALL discard the pending change.
REQ-021 After reset deassertion, if raw_in is high, data_out SHALL rise through the normal debounce path per REQ-016, never earlier.
REQ-022 Reset deassertion SHALL be synchronous to clk externally; the block SHALL contain no reset synchronizer.

Configuration
REQ-023 With macro DEBOUNCE_GLITCH_CNT_EN defined, the block SHALL provide port glitch_count, which increments by 1 on every abort per REQ-015 and saturates at 255.
REQ-024 Without DEBOUNCE_GLITCH_CNT_EN, the block SHALL omit the glitch_count port and all of its logic, with FSM and data_out behaviour identical.

Verification
REQ-025 The bench SHALL check the clean step: with defaults and a 10 ns clock, hold reset high for 24 ns, then set raw_in 0->1 and hold; data_out SHALL rise exactly 6 edges after the first sampling edge and stay 1.
REQ-026 The bench SHALL check short-glitch rejection: raw_in high for 20 ns (2 cycles) then low; data_out SHALL stay 0 and glitch_count SHALL equal 1.
REQ-027 The bench SHALL check a bounce burst: raw_in toggles 1/0 every 10 ns for 80 ns then stays 1; data_out SHALL rise exactly once, 6 edges after the last toggle sample, and the downstream edge_out SHALL show one pulse.
REQ-028 The bench SHALL check reset mid-WAIT: assert reset while counter = 2 in WAIT_HIGH; data_out SHALL remain 0, and after release it SHALL rise only after a full 6-edge period.
REQ-029 The bench SHALL check the falling edge: from STABLE_HIGH, raw_in 1->0; data_out SHALL fall on edge 6, and 300 alternating 1-cycle glitches SHALL leave glitch_count at 255.
REQ-030 The bench SHALL check DEBOUNCE_CYCLES=1 with SYNC_STAGES=3: a raw_in step SHALL produce a data_out change on edge 4.
